// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM controller front end: default sizes,
// read/write encoding and the default-width command record.
package ram_ctrl_pkg;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_QDEPTH = 4;
  localparam int DEF_MAX_RD = 2;
  localparam int DEF_AW     = $clog2(DEF_DEPTH);

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef struct packed {
    logic                 rw;
    logic [DEF_AW-1:0]    addr;
    logic [DEF_WIDTH-1:0] din;
  } cmd_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: head word is read straight from storage.
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    wptr_d  = wptr_q + PW'(do_push);
    rptr_d  = rptr_q + PW'(do_pop);
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/ram_req_queue.sv
// Per-requestor command queue in front of the RAM controller: buffers
// commands, throttles outstanding reads and registers read responses.
module ram_req_queue
  import ram_ctrl_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int QDEPTH = DEF_QDEPTH,
  parameter  int MAX_RD = DEF_MAX_RD,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = $clog2(QDEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_rw,
  input  logic [AW-1:0]    s_addr,
  input  logic [WIDTH-1:0] s_din,
  output logic             req,
  output logic             rw,
  output logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] din,
  input  logic             gnt,
  input  logic             rd_valid,
  input  logic [WIDTH-1:0] rd_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [LW-1:0]    level,
  output logic             err
);
  localparam int OW = $clog2(MAX_RD + 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_RD);

  // Same layout as cmd_t, sized by this instance's parameters.
  typedef struct packed {
    logic             rw;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] din;
  } q_cmd_t;

  q_cmd_t           push_cmd, head;
  logic             full, empty, push, pop, gnt_rd, rd_ok;
  logic [OW-1:0]    out_q, out_d;
  logic             err_q, err_d, rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  assign push_cmd = '{rw: s_rw, addr: s_addr, din: s_din};
  assign s_ready  = !full;
  assign push     = s_valid && s_ready;

  sync_fifo #(.W($bits(q_cmd_t)), .DEPTH(QDEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_cmd),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // A read head waits while the read window is full; writes always go.
  assign req    = !empty && !(head.rw == RW_READ && out_q == OUT_MAX);
  assign pop    = gnt && req;
  assign gnt_rd = pop && head.rw == RW_READ;
  assign rd_ok  = rd_valid && out_q != '0;
  assign rw     = head.rw;
  assign addr   = head.addr;
  assign din    = head.din;

  always_comb begin
    out_d      = out_q;
    if (gnt_rd && !rd_ok)      out_d = out_q + 1'b1;
    else if (rd_ok && !gnt_rd) out_d = out_q - 1'b1;
    err_d      = err_q | (gnt && !req) | (rd_valid && out_q == '0);
    rsp_data_d = rd_valid ? rd_data : rsp_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      out_q       <= out_d;
      err_q       <= err_d;
      rsp_valid_q <= rd_valid;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign err       = err_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_ram_req_queue.sv
// Bench for ram_req_queue: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_ram_req_queue;
  logic       clk, rst, s_valid, s_ready, s_rw, req, rw, gnt, rd_valid, rsp_valid, err;
  logic [7:0] s_addr, s_din, addr, din, rd_data, rsp_data;
  logic [2:0] level;
  int total = 0, bad = 0;

  ram_req_queue dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_rw(s_rw),
    .s_addr(s_addr), .s_din(s_din), .req(req), .rw(rw), .addr(addr), .din(din),
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .level(level), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v; bit [7:0] a, d; bit g;
    int lvl; bit rq, rdy; bit [7:0] ea, ed;
  } vec_t;

  typedef struct { bit rw; bit [7:0] a, d; } mcmd_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic go(input bit v, input bit r, input bit [7:0] a, input bit [7:0] d,
                    input bit g, input bit rv, input bit [7:0] rdd);
    rst = 0; s_valid = v; s_rw = r; s_addr = a; s_din = d;
    gnt = g; rd_valid = rv; rd_data = rdd;
    tick();
  endtask

  function automatic vec_t mk(bit v, bit [7:0] a, bit [7:0] d, bit g,
                              int lvl, bit rq, bit rdy, bit [7:0] ea, bit [7:0] ed);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.g = g;
    t.lvl = lvl; t.rq = rq; t.rdy = rdy; t.ea = ea; t.ed = ed;
    return t;
  endfunction

  vec_t  tbl [11];
  mcmd_t mq[$];
  int    mout;
  bit    merr, mrv, mreq, mhrd, mpop, mrdok;
  bit [7:0] mrd;

  initial begin
    // Write-only traffic: single push/grant, then fill to full and drain.
    tbl[0]  = mk(1, 8'h10, 8'hA5, 0, 1, 1, 1, 8'h10, 8'hA5);
    tbl[1]  = mk(0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 8'h00);
    tbl[2]  = mk(1, 8'h01, 8'h11, 0, 1, 1, 1, 8'h01, 8'h11);
    tbl[3]  = mk(1, 8'h02, 8'h12, 0, 2, 1, 1, 8'h01, 8'h11);
    tbl[4]  = mk(1, 8'h03, 8'h13, 0, 3, 1, 1, 8'h01, 8'h11);
    tbl[5]  = mk(1, 8'h04, 8'h14, 0, 4, 1, 0, 8'h01, 8'h11);
    tbl[6]  = mk(1, 8'h05, 8'h15, 0, 4, 1, 0, 8'h01, 8'h11);
    tbl[7]  = mk(0, 8'h00, 8'h00, 1, 3, 1, 1, 8'h02, 8'h12);
    tbl[8]  = mk(0, 8'h00, 8'h00, 1, 2, 1, 1, 8'h03, 8'h13);
    tbl[9]  = mk(0, 8'h00, 8'h00, 1, 1, 1, 1, 8'h04, 8'h14);
    tbl[10] = mk(0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 8'h00);

    rst = 1; s_valid = 0; s_rw = 0; s_addr = 0; s_din = 0;
    gnt = 0; rd_valid = 0; rd_data = 0;
    tick(); tick();
    rst = 0;
    chk("rst_level", level, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_req", req, 0);
    chk("rst_err", err, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rspd", rsp_data, 0);

    for (int i = 0; i < 11; i++) begin
      go(tbl[i].v, 0, tbl[i].a, tbl[i].d, tbl[i].g, 0, 0);
      chk($sformatf("vec%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("vec%0d_req", i), req, tbl[i].rq);
      chk($sformatf("vec%0d_ready", i), s_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_err", i), err, 0);
      if (tbl[i].rq) begin
        chk($sformatf("vec%0d_rw", i), rw, 0);
        chk($sformatf("vec%0d_addr", i), addr, tbl[i].ea);
        chk($sformatf("vec%0d_din", i), din, tbl[i].ed);
      end
    end

    // Read window: third read held off until a response returns.
    go(1, 1, 8'h20, 0, 0, 0, 0);
    go(1, 1, 8'h21, 0, 0, 0, 0);
    go(1, 1, 8'h22, 0, 0, 0, 0);
    chk("rd_level3", level, 3);
    chk("rd_rw", rw, 1);
    go(0, 0, 0, 0, 1, 0, 0);
    chk("rd_req_after1", req, 1);
    chk("rd_addr_after1", addr, 8'h21);
    go(0, 0, 0, 0, 1, 0, 0);
    chk("rd_req_after2", req, 0);
    chk("rd_level1", level, 1);
    go(0, 0, 0, 0, 0, 1, 8'h3C);
    chk("rd_req_reassert", req, 1);
    chk("rd_rspv", rsp_valid, 1);
    chk("rd_rspd", rsp_data, 8'h3C);
    go(0, 0, 0, 0, 0, 0, 0);
    chk("rd_rspv_low", rsp_valid, 0);
    chk("rd_rspd_hold", rsp_data, 8'h3C);
    go(0, 0, 0, 0, 1, 0, 0);
    chk("rd_level0", level, 0);
    go(0, 0, 0, 0, 0, 1, 8'h3D);
    go(0, 0, 0, 0, 0, 1, 8'h3E);
    chk("rd_rspd2", rsp_data, 8'h3E);
    chk("rd_err", err, 0);

    // Simultaneous push/pop at level 2 across several pointer wraps.
    go(1, 0, 8'h30, 8'h40, 0, 0, 0);
    go(1, 0, 8'h31, 8'h41, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("pp%0d_head", i), din, 8'h40 + i);
      go(1, 0, 8'h32 + i, 8'h42 + i, 1, 0, 0);
      chk($sformatf("pp%0d_level", i), level, 2);
    end
    chk("pp_head_a", din, 8'h4A);
    go(0, 0, 0, 0, 1, 0, 0);
    chk("pp_head_b", din, 8'h4B);
    chk("pp_addr_b", addr, 8'h3B);
    go(0, 0, 0, 0, 1, 0, 0);
    chk("pp_level0", level, 0);
    chk("pp_err", err, 0);

    // Protocol errors: stray grant and stray read data.
    go(0, 0, 0, 0, 1, 0, 0);
    chk("err_gnt", err, 1);
    chk("err_gnt_level", level, 0);
    go(0, 0, 0, 0, 0, 1, 8'h55);
    chk("err_rdv", err, 1);
    chk("err_rdv_level", level, 0);
    go(1, 1, 8'h60, 0, 0, 0, 0);
    go(1, 1, 8'h61, 0, 0, 0, 0);
    go(0, 0, 0, 0, 1, 0, 0);
    chk("err_out_req1", req, 1);
    go(0, 0, 0, 0, 1, 0, 0);
    go(1, 1, 8'h62, 0, 0, 0, 0);
    chk("err_out_blocked", req, 0);
    chk("err_sticky", err, 1);

    // Reset mid-operation: 1 read outstanding, 3 entries queued.
    go(0, 0, 0, 0, 0, 1, 8'h66);
    go(1, 0, 8'h70, 8'h01, 0, 0, 0);
    go(1, 0, 8'h71, 8'h02, 0, 0, 0);
    chk("mid_level3", level, 3);
    rst = 1; s_valid = 1; rd_valid = 1; rd_data = 8'h77;
    tick();
    rst = 0; s_valid = 0; rd_valid = 0;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_req", req, 0);
    chk("mid_rst_ready", s_ready, 1);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rspv", rsp_valid, 0);
    chk("mid_rst_rspd", rsp_data, 0);
    go(0, 0, 0, 0, 0, 1, 8'h88);
    chk("post_rst_rdv_err", err, 1);
    chk("post_rst_level", level, 0);

    // Randomized traffic against the reference model.
    mq.delete(); mout = 0; merr = 0; mrv = 0; mrd = 0;
    rst = 1; tick();
    for (int c = 0; c < 800; c++) begin
      rst      = ($urandom_range(0, 79) == 0);
      s_valid  = $urandom_range(0, 1);
      s_rw     = $urandom_range(0, 1);
      s_addr   = 8'($urandom);
      s_din    = 8'($urandom);
      gnt      = ($urandom_range(0, 2) != 0);
      rd_valid = ($urandom_range(0, 2) == 0);
      rd_data  = 8'($urandom);
      mhrd = (mq.size() != 0) && mq[0].rw;
      mreq = (mq.size() != 0) && !(mhrd && mout == 2);
      if (rst) begin
        mq.delete(); mout = 0; merr = 0; mrv = 0; mrd = 0;
      end else begin
        mpop  = gnt && mreq;
        mrdok = rd_valid && mout > 0;
        if (gnt && !mreq) merr = 1;
        if (rd_valid && mout == 0) merr = 1;
        mout = mout + ((mpop && mhrd) ? 1 : 0) - (mrdok ? 1 : 0);
        mrv = rd_valid;
        if (rd_valid) mrd = rd_data;
        if (s_valid && mq.size() != 4) begin
          if (mpop) void'(mq.pop_front());
          mq.push_back('{rw: s_rw, a: s_addr, d: s_din});
        end else if (mpop) void'(mq.pop_front());
      end
      tick();
      chk("rnd_level", level, mq.size());
      chk("rnd_ready", s_ready, mq.size() != 4);
      chk("rnd_req", req, (mq.size() != 0) && !(mq[0].rw && mout == 2));
      chk("rnd_err", err, merr);
      chk("rnd_rspv", rsp_valid, mrv);
      chk("rnd_rspd", rsp_data, mrd);
      if (mq.size() != 0) begin
        chk("rnd_rw", rw, mq[0].rw);
        chk("rnd_addr", addr, mq[0].a);
        chk("rnd_din", din, mq[0].d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_req_queue.md
RAM_REQ_QUEUE -- requirements
Module: ram_req_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning RAM data width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, meaning RAM word count; address width AW = $clog2(DEPTH).
REQ-003 SHALL have parameter QDEPTH, default 4, meaning command queue entries (power of 2, >=2).
REQ-004 SHALL have parameter MAX_RD, default 2, meaning maximum outstanding granted reads (>=1).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port s_valid, input, 1, meaning the upstream command is valid.
REQ-008 SHALL have port s_ready, output, 1, meaning the queue accepts a command this cycle.
REQ-009 SHALL have port s_rw, input, 1, meaning 0 = write, 1 = read.
REQ-010 SHALL have port s_addr, input, AW, meaning the command address.
REQ-011 SHALL have port s_din, input, WIDTH, meaning write data (don't-care for reads).
REQ-012 SHALL have port req, output, 1, meaning a request to the controller for this requestor slot.
REQ-013 SHALL have ports rw, addr and din, output, 1/AW/WIDTH, meaning the head-entry fields.
REQ-014 SHALL have port gnt, input, 1, meaning the controller consumed the head entry this cycle.
REQ-015 SHALL have ports rd_valid and rd_data, input, 1/WIDTH, meaning in-order read data returned by the controller.
REQ-016 SHALL have ports rsp_valid and rsp_data, output, 1/WIDTH, meaning registered read response to the requestor.
REQ-017 SHALL have port level, output, $clog2(QDEPTH)+1, meaning the current queue occupancy.
REQ-018 SHALL have port err, output, 1, meaning a sticky protocol error.

Function
REQ-019 SHALL push {s_rw,s_addr,s_din} when s_valid && s_ready; s_ready = (level != QDEPTH); no bypass when full.
REQ-020 SHALL present the head entry combinationally from storage (first-word-fall-through); req rises the cycle after a push into an empty queue.
REQ-021 SHALL drive req = (level != 0) && !(head rw==1 && outstanding == MAX_RD); a write head is never blocked by outstanding reads.
REQ-022 SHALL pop the head only when gnt && req; gnt while req==0 SHALL be ignored and SHALL set err.
REQ-023 SHALL, on simultaneous push and pop, leave level unchanged; pointers wrap modulo QDEPTH.
REQ-024 SHALL keep an outstanding counter (0..MAX_RD): +1 on a granted read, -1 on rd_valid, unchanged when both occur in the same cycle.
REQ-025 SHALL ignore rd_valid when outstanding==0 (no change) and set err.
REQ-026 SHALL register rsp_valid <= rd_valid and rsp_data <= rd_data (1-cycle latency); rsp_data holds its value when rsp_valid==0.
REQ-027 SHALL hold s_ready, req, rw, addr and din stable while req==1 && gnt==0.

Reset
REQ-028 SHALL, while rst==1 at a clock edge, clear the read/write pointers, level, outstanding, rsp_valid, rsp_data and err to 0; no push, pop or response occurs on that cycle.
REQ-029 SHALL, when reset is asserted mid-operation, discard queued commands and outstanding read tracking; rd_valid on the cycle after reset deasserts is treated per REQ-025.
REQ-030 SHALL drive s_ready=1 and req=0 in the first cycle after reset.

Structure
REQ-031 SHALL take the command struct typedef (rw, addr, din), the rw encoding constants (RW_WRITE=0, RW_READ=1) and default parameters from the shared package ram_ctrl_pkg.
REQ-032 SHALL implement storage and pointers in one sub-module, sync_fifo (parameterised width and depth, with push, pop, full, empty and level).
REQ-033 SHALL keep the outstanding-read counter, gating and response register in ram_req_queue; one instance per requestor in front of the controller.

Verification
REQ-034 SHALL check: push write (addr 0x10, din 0xA5) into an empty queue -> req=1 next cycle, rw=0, addr=0x10, din=0xA5; gnt -> level returns to 0.
REQ-035 SHALL check: push 4 commands with gnt=0 (QDEPTH=4) -> level=4, s_ready=0; a 5th s_valid is not accepted; one gnt -> s_ready=1 next cycle.
REQ-036 SHALL check: 3 reads queued (MAX_RD=2), each granted -> req drops after the 2nd grant; rd_valid with rd_data=0x3C -> req reasserts, and rsp_valid=1 with rsp_data=0x3C one cycle later.
REQ-037 SHALL check: level=2 with push and gnt in the same cycle -> level stays 2, FIFO order is preserved, and pointer wrap is correct across 10 such cycles.
REQ-038 SHALL check: gnt with an empty queue, and rd_valid with outstanding=0 -> err=1 sticky, with no change to level or outstanding.
REQ-039 SHALL check: rst=1 with 3 entries queued and 1 read outstanding -> next cycle level=0, req=0, s_ready=1, err=0, rsp_valid=0.
